// File: rtl/sr_ff.sv
// Bank of WIDTH independent clocked SR flip-flops with true/complement outputs.
// rst_n is an asynchronous ACTIVE-HIGH reset; the name is historical.
module sr_ff #(
  parameter int   WIDTH     = 1,
  parameter logic RST_VAL   = 1'b0,
  parameter int   BOTH_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b
);

  logic [WIDTH-1:0] both_val;
  logic [WIDTH-1:0] q_next;

  // Next state is written as a plain sum of products so an X on s/r reaches q.
  always_comb begin
    case (BOTH_MODE)
      1:       both_val = '1;
      2:       both_val = q;
      3:       both_val = ~q;
      default: both_val = '0;
    endcase
    q_next = (s & ~r) | (~s & ~r & q) | (s & r & both_val);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q <= {WIDTH{RST_VAL}};
    end else begin
      q <= q_next;
    end
  end

  // Derived from the same register so q and q_b can never disagree.
  assign q_b = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Directed, table-driven bench for sr_ff: default instance, the three s=r=1
// policies, and a 4-bit instance that resets to all ones.
module tb_sr_ff;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_d = 1'b0, r_d = 1'b0;
  logic       s_m = 1'b0, r_m = 1'b0;
  logic [3:0] s_w = 4'h0, r_w = 4'h0;
  logic       q_d, q_b_d, q_m1, q_b_m1, q_m2, q_b_m2, q_m3, q_b_m3;
  logic [3:0] q_w, q_b_w;

  int vectors = 0;
  int miscompares = 0;
  bit rst_seen = 1'b0;

  typedef struct {
    logic s;
    logic r;
    logic exp_q;
  } vec_t;

  vec_t table_v[8];

  always #5 clk = ~clk;

  sr_ff u_def (.clk(clk), .rst_n(rst_n), .s(s_d), .r(r_d), .q(q_d), .q_b(q_b_d));
  sr_ff #(.BOTH_MODE(1)) u_m1 (.clk(clk), .rst_n(rst_n), .s(s_m), .r(r_m), .q(q_m1), .q_b(q_b_m1));
  sr_ff #(.BOTH_MODE(2)) u_m2 (.clk(clk), .rst_n(rst_n), .s(s_m), .r(r_m), .q(q_m2), .q_b(q_b_m2));
  sr_ff #(.BOTH_MODE(3)) u_m3 (.clk(clk), .rst_n(rst_n), .s(s_m), .r(r_m), .q(q_m3), .q_b(q_b_m3));
  sr_ff #(.WIDTH(4), .RST_VAL(1'b1)) u_w4 (.clk(clk), .rst_n(rst_n), .s(s_w), .r(r_w), .q(q_w), .q_b(q_b_w));

  task automatic check_output(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs on the falling edge, then look just after the next rising edge.
  task automatic apply_stimulus(input logic sd, input logic rd, input logic sm, input logic rm,
                                input logic [3:0] sw, input logic [3:0] rw);
    @(negedge clk);
    s_d = sd; r_d = rd; s_m = sm; r_m = rm; s_w = sw; r_w = rw;
    @(posedge clk);
    #1;
  endtask

  // The complement must track q on every instance once reset has been seen.
  always @(negedge clk) begin
    if (rst_seen) begin
      check_output("qb_def", {3'b0, q_b_d}, {3'b0, ~q_d});
      check_output("qb_m3", {3'b0, q_b_m3}, {3'b0, ~q_m3});
      check_output("qb_w4", q_b_w, ~q_w);
    end
  end

  initial begin
    table_v[0] = '{1'b1, 1'b1, 1'b0};
    table_v[1] = '{1'b0, 1'b1, 1'b0};
    table_v[2] = '{1'b0, 1'b0, 1'b0};
    table_v[3] = '{1'b1, 1'b0, 1'b1};
    table_v[4] = '{1'b0, 1'b0, 1'b1};
    table_v[5] = '{1'b1, 1'b1, 1'b0};
    table_v[6] = '{1'b1, 1'b0, 1'b1};
    table_v[7] = '{1'b0, 1'b1, 1'b0};

    #2 rst_n = 1'b1;
    #1;
    rst_seen = 1'b1;
    check_output("rst_q", {3'b0, q_d}, 4'h0);
    check_output("rst_qb", {3'b0, q_b_d}, 4'h1);
    check_output("rst_w4_q", q_w, 4'hF);
    check_output("rst_w4_qb", q_b_w, 4'h0);

    // Clock edges with s=1 must be ignored while reset is held.
    #25 s_d = 1'b1;
    #8;
    check_output("rst_hold_s", {3'b0, q_d}, 4'h0);
    #1 rst_n = 1'b0;
    s_d = 1'b0;

    foreach (table_v[i]) begin
      apply_stimulus(table_v[i].s, table_v[i].r, 1'b0, 1'b0, 4'h0, 4'h0);
      check_output($sformatf("vec%0d_q", i), {3'b0, q_d}, {3'b0, table_v[i].exp_q});
      check_output($sformatf("vec%0d_qb", i), {3'b0, q_b_d}, {3'b0, ~table_v[i].exp_q});
    end

    // Reset between edges overrides a set flop immediately.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check_output("pre_mid_rst", {3'b0, q_d}, 4'h1);
    #2 rst_n = 1'b1;
    #1;
    check_output("mid_rst_q", {3'b0, q_d}, 4'h0);
    check_output("mid_rst_qb", {3'b0, q_b_d}, 4'h1);
    #1 rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check_output("post_rst_set", {3'b0, q_d}, 4'h1);

    // Simultaneous s=r=1 for three edges on each policy instance.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    check_output("m1_e1", {3'b0, q_m1}, 4'h1);
    check_output("m2_e1", {3'b0, q_m2}, 4'h0);
    check_output("m3_e1", {3'b0, q_m3}, 4'h1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    check_output("m1_e2", {3'b0, q_m1}, 4'h1);
    check_output("m2_e2", {3'b0, q_m2}, 4'h0);
    check_output("m3_e2", {3'b0, q_m3}, 4'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    check_output("m1_e3", {3'b0, q_m1}, 4'h1);
    check_output("m2_e3", {3'b0, q_m2}, 4'h0);
    check_output("m3_e3", {3'b0, q_m3}, 4'h1);

    // 4-bit instance still holds its all-ones reset value.
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0110);
    check_output("w4_q", q_w, 4'b1001);
    check_output("w4_qb", q_b_w, 4'b0110);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
    check_output("w4_both", q_w, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000);
    check_output("w4_set", q_w, 4'b1010);

    // Unknown inputs propagate, and reset clears the unknown.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    apply_stimulus(1'bx, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check_output("x_prop", {3'b0, q_d}, {3'b0, 1'bx});
    #2 rst_n = 1'b1;
    #1;
    check_output("x_clear", {3'b0, q_d}, 4'h0);
    s_d = 1'b0;
    #1 rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check_output("x_clear_hold", {3'b0, q_d}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
